// File: rtl/bp_pkg.sv
// Shared types and widths for the branch-prediction resolve path.
package bp_pkg;

  localparam int unsigned BHT_CTR_W = 2;
  localparam int unsigned PC_W      = 32;

  // Prediction metadata captured at fetch, held until the branch resolves
  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [BHT_CTR_W-1:0] bht_rdata;
    logic                 pred;
    logic [PC_W-1:0]      target;
  } bp_meta_t;

endpackage

// File: rtl/bp_meta_fifo.sv
// Circular buffer of in-flight branch metadata with pop and wrong-path flush.
module bp_meta_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  bp_meta_t push_data,
  input  logic     pop,
  input  logic     flush,
  output bp_meta_t head_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bp_meta_t         mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head_inc;

  assign head_inc = head + PTR_W'(1);

  // Pointer and occupancy tracking; a flush drops everything younger than the head
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head_inc;
      end
      if (flush) begin
        tail  <= head_inc;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Entry storage; contents are meaningless outside the head..tail window
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail] <= push_data;
    end
  end

  assign head_data = mem[head];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/bp_resolve_fifo.sv
// Holds branch predictions until EX resolves them in order, then emits the
// BHT update and, on a mispredict, a fetch redirect with wrong-path flush.
module bp_resolve_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic [PC_W-1:0]      push_pc,
  input  logic [BHT_CTR_W-1:0] push_bht_rdata,
  input  logic                 push_pred,
  input  logic [PC_W-1:0]      push_target,
  output logic                 full,
  input  logic                 resolve_valid,
  input  logic                 resolve_br_en,
  input  logic [PC_W-1:0]      resolve_target,
  output logic                 bht_write,
  output logic [PC_W-1:0]      pc_address_write,
  output logic [BHT_CTR_W-1:0] bht_rdata_ret,
  output logic                 mispredict,
  output logic                 redirect_valid,
  output logic [PC_W-1:0]      redirect_pc,
  output logic                 underflow_err
);

  bp_meta_t head;
  bp_meta_t push_meta;
  logic     fifo_full;
  logic     fifo_empty;
  logic     resolve_hit;
  logic     mis_now;
  logic     push_ok;

  assign push_meta = '{pc: push_pc, bht_rdata: push_bht_rdata,
                       pred: push_pred, target: push_target};

  bp_meta_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_meta),
    .pop       (resolve_hit),
    .flush     (mis_now),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign resolve_hit = resolve_valid && !fifo_empty;

  // Wrong direction, or right "taken" direction with the wrong target
  always_comb begin
    mis_now = 1'b0;
    if (resolve_hit) begin
      mis_now = (head.pred != resolve_br_en) ||
                (head.pred && resolve_br_en && (head.target != resolve_target));
    end
  end

  // A resolve frees a slot, so a full buffer still accepts; wrong-path pushes are dropped
  assign push_ok = push_valid && (!fifo_full || resolve_hit) && !mis_now;
  assign full    = fifo_full;

  // Registered single-cycle update/redirect pulses plus sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bht_write        <= 1'b0;
      pc_address_write <= '0;
      bht_rdata_ret    <= '0;
      mispredict       <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      underflow_err    <= 1'b0;
    end else begin
      bht_write        <= resolve_hit;
      pc_address_write <= resolve_hit ? head.pc : '0;
      bht_rdata_ret    <= resolve_hit ? head.bht_rdata : '0;
      mispredict       <= mis_now;
      redirect_valid   <= mis_now;
      redirect_pc      <= mis_now ? (resolve_br_en ? resolve_target : head.pc + PC_W'(4)) : '0;
      if (resolve_valid && fifo_empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule
